// File: rtl/t06_collision_pkg.sv
// Shared definitions for the multi-cycle snake collision scanner:
// cause bit positions, scanner states and the length-width helper.
package t06_collision_pkg;

    localparam int CAUSE_BORDER = 0;
    localparam int CAUSE_WALL   = 1;
    localparam int CAUSE_SELF   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width needed to hold a segment count of 0..max_length inclusive.
    function automatic int len_width(input int max_length);
        return $clog2(max_length + 1);
    endfunction

endpackage

// File: rtl/t06_segment_lanes.sv
// LANES parallel head-vs-body comparators; segments at or beyond the active
// length are masked so stale body entries can never report a self-hit.
module t06_segment_lanes #(
    parameter int COORD_W    = 4,
    parameter int MAX_LENGTH = 30,
    parameter int LANES      = 2,
    parameter int IDX_W      = 6,
    parameter int LEN_W      = 5
) (
    input  logic [COORD_W-1:0]            head_x_i,
    input  logic [COORD_W-1:0]            head_y_i,
    input  logic [MAX_LENGTH*COORD_W-1:0] body_x_i,
    input  logic [MAX_LENGTH*COORD_W-1:0] body_y_i,
    input  logic [IDX_W-1:0]              idx_i,
    input  logic [LEN_W-1:0]              len_i,
    output logic [LANES-1:0]              lane_hit_o,
    output logic                          any_hit_o
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [IDX_W-1:0]   seg;
            logic [COORD_W-1:0] seg_x;
            logic [COORD_W-1:0] seg_y;

            assign seg = idx_i + IDX_W'(gi);

            // Explicit mux keeps lanes past MAX_LENGTH from indexing outside the body vectors.
            always_comb begin
                seg_x = '0;
                seg_y = '0;
                for (int i = 0; i < MAX_LENGTH; i++) begin
                    if (seg == IDX_W'(i)) begin
                        seg_x = body_x_i[i*COORD_W +: COORD_W];
                        seg_y = body_y_i[i*COORD_W +: COORD_W];
                    end
                end
            end

            assign lane_hit_o[gi] = (seg < IDX_W'(len_i)) && (seg_x == head_x_i) && (seg_y == head_y_i);
        end
    endgenerate

    assign any_hit_o = |lane_hit_o;

endmodule

// File: rtl/t06_collision_scanner.sv
// Multi-cycle snake collision check: captures the board on start, scans the body
// LANES segments per cycle with early exit, and reports a registered result with a done pulse.
module t06_collision_scanner
    import t06_collision_pkg::*;
#(
    parameter int COORD_W    = 4,
    parameter int MAX_LENGTH = 30,
    parameter int NUM_APPLES = 2,
    parameter int GRID_W     = 20,
    parameter int GRID_H     = 10,
    parameter int LANES      = 2
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             start,
    input  logic [COORD_W-1:0]               head_x,
    input  logic [COORD_W-1:0]               head_y,
    input  logic [COORD_W-1:0]               border_x_min,
    input  logic [COORD_W-1:0]               border_x_max,
    input  logic [COORD_W-1:0]               border_y_min,
    input  logic [COORD_W-1:0]               border_y_max,
    input  logic [$clog2(MAX_LENGTH+1)-1:0]  snake_len,
    input  logic [MAX_LENGTH*COORD_W-1:0]    body_x,
    input  logic [MAX_LENGTH*COORD_W-1:0]    body_y,
    input  logic [NUM_APPLES*COORD_W-1:0]    apple_x,
    input  logic [NUM_APPLES*COORD_W-1:0]    apple_y,
    input  logic [NUM_APPLES-1:0]            apple_valid,
    input  logic [GRID_W*GRID_H-1:0]         wall_array,
    output logic                             busy,
    output logic                             done,
    output logic                             bad_collision,
    output logic [2:0]                       cause,
    output logic [NUM_APPLES-1:0]            apple_hit
);

    localparam int LEN_W  = len_width(MAX_LENGTH);
    localparam int IDX_W  = $clog2(MAX_LENGTH + LANES + 1);
    localparam int CELLS  = GRID_W * GRID_H;
    localparam int WIDX_W = $clog2(CELLS);

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [LEN_W-1:0]                len_q;
    logic [COORD_W-1:0]              head_x_q, head_y_q;
    logic [COORD_W-1:0]              bx_min_q, bx_max_q, by_min_q, by_max_q;
    logic [MAX_LENGTH*COORD_W-1:0]   body_x_q, body_y_q;
    logic [NUM_APPLES*COORD_W-1:0]   apple_x_q, apple_y_q;
    logic [NUM_APPLES-1:0]           apple_valid_q;
    logic [CELLS-1:0]                wall_q;
    logic                            bad_q;
    logic [2:0]                      cause_q;
    logic [NUM_APPLES-1:0]           apple_hit_q;

    logic                            capture;
    logic                            load_result;
    logic [LEN_W-1:0]                len_clamped;
    logic [LANES-1:0]                lane_hit;
    logic                            self_hit;
    logic                            border_hit;
    logic                            in_grid;
    logic [WIDX_W-1:0]               wall_idx;
    logic                            wall_hit;
    logic [2:0]                      cause_c;
    logic [NUM_APPLES-1:0]           apple_hit_c;

    assign len_clamped = (snake_len > LEN_W'(MAX_LENGTH)) ? LEN_W'(MAX_LENGTH) : snake_len;

    t06_segment_lanes #(
        .COORD_W    (COORD_W),
        .MAX_LENGTH (MAX_LENGTH),
        .LANES      (LANES),
        .IDX_W      (IDX_W),
        .LEN_W      (LEN_W)
    ) u_lanes (
        .head_x_i   (head_x_q),
        .head_y_i   (head_y_q),
        .body_x_i   (body_x_q),
        .body_y_i   (body_y_q),
        .idx_i      (idx_q),
        .len_i      (len_q),
        .lane_hit_o (lane_hit),
        .any_hit_o  (self_hit)
    );

    // Board checks depend only on captured values, so they are stable for the whole scan.
    assign border_hit = (head_x_q <= bx_min_q) || (head_x_q >= bx_max_q) ||
                        (head_y_q <= by_min_q) || (head_y_q >= by_max_q);
    assign in_grid    = (int'(head_x_q) < GRID_W) && (int'(head_y_q) < GRID_H);
    assign wall_idx   = WIDX_W'(int'(head_y_q) * GRID_W + int'(head_x_q));
    assign wall_hit   = in_grid && wall_q[wall_idx];

    generate
        for (genvar gi = 0; gi < NUM_APPLES; gi++) begin : g_apple
            assign apple_hit_c[gi] = apple_valid_q[gi] &&
                                     (apple_x_q[gi*COORD_W +: COORD_W] == head_x_q) &&
                                     (apple_y_q[gi*COORD_W +: COORD_W] == head_y_q);
        end
    endgenerate

    always_comb begin
        cause_c               = '0;
        cause_c[CAUSE_BORDER] = border_hit;
        cause_c[CAUSE_WALL]   = wall_hit;
        cause_c[CAUSE_SELF]   = self_hit;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        capture     = 1'b0;
        load_result = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    capture = 1'b1;
                end
            end
            SCAN: begin
                idx_d = idx_q + IDX_W'(LANES);
                if (self_hit || ((idx_q + IDX_W'(LANES)) >= IDX_W'(len_q))) begin
                    state_d     = DONE;
                    load_result = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    capture = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            bad_q       <= 1'b0;
            cause_q     <= '0;
            apple_hit_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load_result) begin
                bad_q       <= |cause_c;
                cause_q     <= cause_c;
                apple_hit_q <= apple_hit_c;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            len_q         <= '0;
            head_x_q      <= '0;
            head_y_q      <= '0;
            bx_min_q      <= '0;
            bx_max_q      <= '0;
            by_min_q      <= '0;
            by_max_q      <= '0;
            body_x_q      <= '0;
            body_y_q      <= '0;
            apple_x_q     <= '0;
            apple_y_q     <= '0;
            apple_valid_q <= '0;
            wall_q        <= '0;
        end else if (capture) begin
            len_q         <= len_clamped;
            head_x_q      <= head_x;
            head_y_q      <= head_y;
            bx_min_q      <= border_x_min;
            bx_max_q      <= border_x_max;
            by_min_q      <= border_y_min;
            by_max_q      <= border_y_max;
            body_x_q      <= body_x;
            body_y_q      <= body_y;
            apple_x_q     <= apple_x;
            apple_y_q     <= apple_y;
            apple_valid_q <= apple_valid;
            wall_q        <= wall_array;
        end
    end

    assign busy          = (state_q == SCAN);
    assign done          = (state_q == DONE);
    assign bad_collision = bad_q;
    assign cause         = cause_q;
    assign apple_hit     = apple_hit_q;

endmodule
